// File: rtl/buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_pkg
//  Description : Shared constants and helpers for the buffer family:
//                default word width / depth, a clog2 helper and the
//                wrap-bit pointer width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package buffer_pkg;

    localparam int C_WIDTH_DEF = 8;
    localparam int C_DEPTH_DEF = 4;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Address bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_mem.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_mem
//  Description : DEPTH x WIDTH register array, synchronous write port and
//                asynchronous (combinational) read port. Not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_mem
    import buffer_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEF,
    parameter int DEPTH = C_DEPTH_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled; contents hold otherwise.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_fifo
//  Description : Registered valid/ready FIFO of WIDTH-bit words, DEPTH deep.
//                Wrap-bit pointers distinguish full from empty; a word
//                pushed at one edge is visible after that edge.
//                Optional macro BUFFER_FIFO_STATUS_EN adds full / empty /
//                almost_full outputs and zeroes out_data while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_fifo
    import buffer_pkg::*;
#(
    parameter int WIDTH       = C_WIDTH_DEF,
    parameter int DEPTH       = C_DEPTH_DEF,
    parameter int ALMOST_FULL = 3,
    parameter int PW          = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [PW-1:0]    count
`ifdef BUFFER_FIFO_STATUS_EN
    ,
    output logic             full,
    output logic             empty,
    output logic             almost_full
`endif
);

    localparam int            AW   = PW - 1;
    localparam logic [PW-1:0] C_AF = PW'(ALMOST_FULL);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    // Flags come only from registered pointers, never from the opposite port.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // in_ready is also held low while reset is asserted.
    assign in_ready  = !w_full && !rst;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    // Pointer advance; natural wrap modulo 2*DEPTH toggles the wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: +1 push only, -1 pop only, unchanged on both or neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

`ifdef BUFFER_FIFO_STATUS_EN
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= C_AF);
    // Deterministic zero on the data bus while nothing is buffered.
    assign out_data    = w_empty ? '0 : w_rdata;
`else
    logic w_unused_af;
    assign w_unused_af = (r_count >= C_AF);
    assign out_data    = w_rdata;
`endif

endmodule
`default_nettype wire
